// File: rtl/switch_allocator.sv
// Per-output packet switch allocator for the 3-port router (x, y, local).
// Each output owns a round-robin arbiter that locks onto one input for a whole
// packet, drives the output mux select and pops flits from the winning FIFO.
// Array index b follows the port bit order: 2 = x, 1 = y, 0 = local.
module switch_allocator #(
  parameter int unsigned PKT_LEN = 4,
  parameter int unsigned CNT_W   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] in_valid,
  input  logic [1:0] dir_x,
  input  logic [1:0] dir_y,
  input  logic [1:0] dir_local,
  input  logic [2:0] fail,
  input  logic [2:0] out_ready,
  output logic [1:0] control_x,
  output logic [1:0] control_y,
  output logic [1:0] control_local,
  output logic [2:0] grant,
  output logic [2:0] busy,
  output logic [2:0] abort
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state [3];
  logic [1:0]       r_owner [3];
  logic [CNT_W-1:0] r_cnt   [3];
  logic [1:0]       r_rr    [3];
  logic [2:0]       r_abort;

  logic [1:0] w_dir   [3];
  logic [2:0] w_req   [3];
  logic [1:0] w_win   [3];
  logic [2:0] w_own_oh[3];
  logic [2:0] w_xfer;
  logic [2:0] w_kill;
  logic [2:0] w_owned;
  logic [2:0] w_grant;

  // Select/route code (01 x, 10 y, 11 local) to one-hot in port bit order.
  function automatic logic [2:0] code_onehot(input logic [1:0] c);
    logic [2:0] oh;
    case (c)
      2'b01:   oh = 3'b100;
      2'b10:   oh = 3'b010;
      2'b11:   oh = 3'b001;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // First requesting code after 'last' in the cyclic order x -> y -> local.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] c;
    logic [1:0] pick;
    pick = 2'b00;
    c    = last;
    for (int unsigned k = 0; k < 3; k++) begin
      c = (c == 2'd3) ? 2'd1 : c + 2'd1;
      if (pick == 2'b00 && |(req & code_onehot(c))) pick = c;
    end
    return pick;
  endfunction

  assign w_dir[2] = dir_x;
  assign w_dir[1] = dir_y;
  assign w_dir[0] = dir_local;

  // Request matrix, round-robin winners, transfer/fail detection and pop grants.
  // An input already owning some output is masked from new requests so a
  // mid-packet dir change can never grant the same input on two outputs.
  always_comb begin
    w_owned = '0;
    w_grant = '0;
    w_xfer  = '0;
    w_kill  = '0;
    for (int unsigned o = 0; o < 3; o++) begin
      w_own_oh[o] = code_onehot(r_owner[o]);
      if (r_state[o] == S_BUSY) w_owned = w_owned | w_own_oh[o];
    end
    for (int unsigned o = 0; o < 3; o++) begin
      w_req[o] = '0;
      for (int unsigned i = 0; i < 3; i++) begin
        w_req[o][i] = in_valid[i] && (w_dir[i] == 2'(3 - o)) && !fail[i] && !w_owned[i];
      end
      w_win[o]  = rr_pick(w_req[o], r_rr[o]);
      w_kill[o] = (r_state[o] == S_BUSY) && |(w_own_oh[o] & fail);
      w_xfer[o] = (r_state[o] == S_BUSY) && |(w_own_oh[o] & in_valid & ~fail) && out_ready[o];
      if (w_xfer[o]) w_grant = w_grant | w_own_oh[o];
    end
  end

  // Per-output connection state machine with registered select and abort.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_abort <= '0;
      for (int unsigned o = 0; o < 3; o++) begin
        r_state[o] <= S_IDLE;
        r_owner[o] <= 2'b00;
        r_cnt[o]   <= '0;
        r_rr[o]    <= 2'b11;
      end
    end else begin
      r_abort <= '0;
      for (int unsigned o = 0; o < 3; o++) begin
        case (r_state[o])
          S_IDLE: begin
            if (w_win[o] != 2'b00) begin
              r_state[o] <= S_BUSY;
              r_owner[o] <= w_win[o];
              r_cnt[o]   <= CNT_W'(PKT_LEN - 1);
              r_rr[o]    <= w_win[o];
            end
          end
          S_BUSY: begin
            if (w_kill[o]) begin
              r_state[o] <= S_IDLE;
              r_owner[o] <= 2'b00;
              r_abort[o] <= 1'b1;
            end else if (w_xfer[o]) begin
              if (r_cnt[o] == '0) begin
                r_state[o] <= S_IDLE;
                r_owner[o] <= 2'b00;
              end else begin
                r_cnt[o] <= r_cnt[o] - 1'b1;
              end
            end
          end
          default: begin
            r_state[o] <= S_IDLE;
            r_owner[o] <= 2'b00;
          end
        endcase
      end
    end
  end

  assign control_x     = r_owner[2];
  assign control_y     = r_owner[1];
  assign control_local = r_owner[0];
  assign busy          = {r_state[2] == S_BUSY, r_state[1] == S_BUSY, r_state[0] == S_BUSY};
  assign abort         = r_abort;
  assign grant         = w_grant;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator with hand-computed expectations.
module tb_switch_allocator;

  logic       clk;
  logic       rst_n;
  logic [2:0] in_valid;
  logic [1:0] dir_x;
  logic [1:0] dir_y;
  logic [1:0] dir_local;
  logic [2:0] fail;
  logic [2:0] out_ready;
  logic [1:0] control_x;
  logic [1:0] control_y;
  logic [1:0] control_local;
  logic [2:0] grant;
  logic [2:0] busy;
  logic [2:0] abort;

  int n_checks;
  int n_errors;

  switch_allocator #(.PKT_LEN(4), .CNT_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .dir_x        (dir_x),
    .dir_y        (dir_y),
    .dir_local    (dir_local),
    .fail         (fail),
    .out_ready    (out_ready),
    .control_x    (control_x),
    .control_y    (control_y),
    .control_local(control_local),
    .grant        (grant),
    .busy         (busy),
    .abort        (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b1;
    in_valid  = '0;
    dir_x     = '0;
    dir_y     = '0;
    dir_local = '0;
    fail      = '0;
    out_ready = '0;
    tick();
    tick();
    rst_n = 1'b0;
  endtask

  logic [1:0] exp_code [4];
  logic [2:0] exp_gnt  [4];
  logic       rdy_y    [7];
  int         n_gnt;

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_code = '{2'b01, 2'b10, 2'b11, 2'b01};
    exp_gnt  = '{3'b100, 3'b010, 3'b001, 3'b100};
    rdy_y    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Quiet after reset
    do_reset();
    for (int i = 0; i < 10; i++) begin
      #1 check("idle_all", {control_x, control_y, control_local, busy, grant, abort}, '0);
      tick();
    end

    // Single packet x -> y, with a dir change mid-packet that must be ignored
    out_ready = 3'b111;
    in_valid  = 3'b100;
    dir_x     = 2'b10;
    #1 check("t2_pre_grant", grant, 3'b000);
    check("t2_pre_ctrl_y", control_y, 2'b00);
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) dir_x = 2'b11;
      #1 check("t2_ctrl_y", control_y, 2'b01);
      check("t2_grant", grant, 3'b100);
      check("t2_busy", busy, 3'b010);
      check("t2_ctrl_local", control_local, 2'b00);
      tick();
    end
    in_valid = '0;
    dir_x    = '0;
    #1 check("t2_release", {control_y, busy, grant}, '0);
    tick();

    // Three inputs contending for local: round-robin with bubbles
    do_reset();
    out_ready = 3'b111;
    in_valid  = 3'b111;
    dir_x     = 2'b11;
    dir_y     = 2'b11;
    dir_local = 2'b11;
    #1 check("t3_pre", {control_local, grant}, '0);
    tick();
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 4; k++) begin
        #1 check("t3_ctrl_local", control_local, exp_code[p]);
        check("t3_grant", grant, exp_gnt[p]);
        tick();
      end
      #1 check("t3_bubble", {control_local, busy, grant}, '0);
      tick();
    end

    // Three parallel connections
    do_reset();
    out_ready = 3'b111;
    in_valid  = 3'b111;
    dir_x     = 2'b10;
    dir_y     = 2'b01;
    dir_local = 2'b11;
    tick();
    for (int k = 0; k < 4; k++) begin
      #1 check("t4_ctrl", {control_x, control_y, control_local}, {2'b10, 2'b01, 2'b11});
      check("t4_grant", grant, 3'b111);
      check("t4_busy", busy, 3'b111);
      tick();
    end
    in_valid = '0;
    #1 check("t4_release", {busy, grant}, '0);

    // Stall on output y mid-packet
    do_reset();
    out_ready = 3'b111;
    in_valid  = 3'b100;
    dir_x     = 2'b10;
    tick();
    n_gnt = 0;
    for (int c = 0; c < 7; c++) begin
      out_ready = {1'b1, rdy_y[c], 1'b1};
      #1 check("t5_grant", grant, rdy_y[c] ? 3'b100 : 3'b000);
      check("t5_ctrl_y", control_y, 2'b01);
      if (grant[2]) n_gnt++;
      tick();
    end
    in_valid = '0;
    #1 check("t5_total_grants", n_gnt, 4);
    check("t5_release", {control_y, busy}, '0);
    tick();

    // Fail of the owner mid-packet, pending request granted afterwards
    do_reset();
    out_ready = 3'b111;
    in_valid  = 3'b110;
    dir_x     = 2'b10;
    dir_y     = 2'b10;
    tick();
    for (int k = 0; k < 2; k++) begin
      #1 check("t6_grant_x", grant, 3'b100);
      check("t6_ctrl_y", control_y, 2'b01);
      tick();
    end
    fail = 3'b100;
    #1 check("t6_fail_cycle_grant", grant, 3'b000);
    check("t6_fail_cycle_abort", abort, 3'b000);
    tick();
    #1 check("t6_abort", abort, 3'b010);
    check("t6_released", {control_y, busy, grant}, '0);
    tick();
    #1 check("t6_abort_clear", abort, 3'b000);
    check("t6_ctrl_y_next", control_y, 2'b10);
    check("t6_grant_y", grant, 3'b010);
    tick();
    #1 check("t6_abort_once", abort, 3'b000);

    // Reset in the middle of a packet: silent drop
    rst_n = 1'b1;
    tick();
    in_valid = '0;
    fail     = '0;
    #1 check("t7_rst_mid", {control_x, control_y, control_local, busy, grant, abort}, '0);
    rst_n = 1'b0;
    tick();
    #1 check("t7_after", {control_x, control_y, control_local, busy, abort}, '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-output packet arbiter for the 3-port router (ports x, y, local).
- Takes the per-input route decisions (2-bit direction codes) and resolves conflicts when several inputs target the same output. Arbitration is round-robin.
- Holds each granted connection for a whole packet and drives the 2-bit select lines of the three output data_selector41 muxes.
- Returns per-input pop grants to the input FIFOs.

Parameters:
PKT_LEN, 4, flits per packet; legal range 1..2**CNT_W
CNT_W, 3, width of the per-output flit counter

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous, active-high reset (name kept per codebase; 1 = reset)
in_valid  input  3  head flit present at input FIFO; bit2=x, bit1=y, bit0=local
dir_x  input  2  route of input x: 00 none, 01 to x, 10 to y, 11 to local
dir_y  input  2  route of input y, same encoding
dir_local  input  2  route of input local, same encoding
fail  input  3  input fault, same bit order; faulty input is never granted
out_ready  input  3  downstream of output can accept a flit; bit2=x, bit1=y, bit0=local
control_x  output  2  mux select of output x: 00 none, 01 data x, 10 data y, 11 data local
control_y  output  2  mux select of output y, same encoding
control_local  output  2  mux select of output local, same encoding
grant  output  3  pop strobe to input FIFO, one flit transferred this cycle
busy  output  3  output port currently owned
abort  output  3  one-cycle pulse: owned packet dropped due to fail

Behaviour:
Structure:
- Three identical output arbiters, index o in {x, y, local}.
- Each has registers: state (IDLE/BUSY), owner[1:0] (select code), cnt[CNT_W-1:0], rr_last[1:0].

Reset (rst_n=1 at clk edge):
- state=IDLE, owner=00, cnt=0, rr_last=11 (local). x therefore has top priority first.
- control_*=00, busy=000, abort=000, grant=000.
- Reset mid-packet discards the connection silently: no abort pulse.

IDLE:
- Candidate input i for output o: in_valid[i] && dir_i==code(o) && !fail[i].
- Round-robin winner is the first candidate after rr_last in the cyclic order x->y->local->x.
- On a winner:
  - next cycle state=BUSY, owner=winner code, cnt=PKT_LEN-1.
  - rr_last=winner code, updated at grant time.
- With no candidate, stay IDLE.
- Latency: request visible at edge N -> control_o and busy[o] valid after edge N+1.

BUSY:
- control_o=owner (registered); busy[o]=1.
- Transfer cycle when in_valid[owner] && out_ready[o] && !fail[owner].
- grant[owner] is combinational from registered state plus these inputs; it is asserted only in transfer cycles.
- On transfer with cnt!=0: cnt decrements.
- On transfer with cnt==0 (last flit): next state=IDLE, control_o=00.
- Stall (in_valid or out_ready low): hold everything, grant=0, no timeout.

Fail mid-packet:
- If fail[owner]=1 while BUSY, next cycle state=IDLE and control_o=00.
- abort[o] pulses for that one cycle. No grant is issued in the fail cycle.

Back-to-back packets:
- Arbitration only happens in IDLE, so there is a mandatory 1-cycle bubble between packets on the same output.
- A request present during the last-flit cycle is evaluated in the following IDLE cycle.

Concurrency and invariants:
- One input has exactly one dir, so at most one output can grant a given input per cycle.
- grant is one-hot-or-zero per input.
- Different outputs run fully in parallel; up to three simultaneous connections.

Boundary cases:
- dir=00 or in_valid=0 is never a candidate.
- A change in dir_i while input i owns an output is ignored until release.
- PKT_LEN=1: BUSY lasts exactly one transfer.

Test Plan:
- Reset, then no requests -> all control_*=00, busy=000, grant=000 for 10 cycles; rst_n=1 mid-BUSY -> next cycle all outputs 00, abort=000.
- in_valid=100, dir_x=10, out_ready=111, PKT_LEN=4 -> control_y=01 from cycle 2; grant[2]=1 for 4 consecutive cycles; control_y=00 and busy[1]=0 afterwards.
- x, y, local all dir=11 continuously -> control_local order 01, 10, 11, 01; each packet 4 grants with a 1-cycle bubble between packets.
- Parallel case: dir_x=10, dir_y=01, dir_local=11, all valid -> control_y=01, control_x=10, control_local=11 simultaneously, and grant=111 each cycle.
- Stall: out_ready[1] low for 3 cycles mid-packet -> grant[owner]=0 and cnt held; the packet still totals exactly 4 grants.
- fail[2] raised after 2 grants of x->y -> no further grant[2], control_y=00 next cycle, abort[1]=1 for exactly one cycle; a pending y->y request is granted afterwards.
